ps2_host_tx: RTL and testbench

- Host-to-device transmitter for the PS/2 host controller; the counterpart of the receive path.
- Accepts one command byte from the bus-side logic and performs the PS/2 request-to-send sequence: clock inhibit, then data low, then clock release.
- Shifts the byte out on device-generated clock edges, then checks the device ACK.
- Drives open-drain output enables only; line synchronisation and edge detection live upstream and supply ps2_clk_posedge / ps2_clk_negedge pulses.

---
 rtl/ps2_host_pkg.sv | 38 +++
 rtl/ps2_host_tx_timer.sv | 33 +++
 rtl/ps2_host_tx.sv | 184 ++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_host_pkg.sv
// rtl/ps2_host_pkg.sv - shared state type, timing constants and frame helpers for the PS/2 host transmitter
package ps2_host_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        WAIT_START,
        SHIFT,
        WAIT_IDLE,
        DONE
    } ps2_tx_state_t;

    localparam int T_100US_CYCLES     = 5000;
    localparam int T_15MS_CYCLES      = 750000;
    localparam int T_2MS_CYCLES       = 100000;
    localparam int PS2_TX_FRAME_EDGES = 11;

    // Level driven after device negedge idx: 1..8 data LSB first, 9 parity, 10 stop.
    function automatic logic frame_bit(input logic [7:0] data, input logic parity,
                                       input logic [3:0] idx);
        logic b;
        b = 1'b1;
        if (idx >= 4'd1 && idx <= 4'd8) begin
            b = data[3'(idx - 4'd1)];
        end else if (idx == 4'd9) begin
            b = parity;
        end
        return b;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ps2_host_tx_timer.sv
// rtl/ps2_host_tx_timer.sv - loadable saturating down-counter shared by all timed transmitter states
module ps2_host_tx_timer #(
    parameter int W = 20
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device transmitter (request-to-send, shift, ACK); PS2_HOST_TX_RETRY_EN adds one automatic resend
module ps2_host_tx
    import ps2_host_pkg::*;
#(
    parameter int INHIBIT_CYCLES       = T_100US_CYCLES,
    parameter int START_TIMEOUT_CYCLES = T_15MS_CYCLES,
    parameter int XFER_TIMEOUT_CYCLES  = T_2MS_CYCLES
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       ps2_clk_posedge,
    input  logic       ps2_clk_negedge,
    input  logic       ps2_data_in,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int TW = $clog2(max3(INHIBIT_CYCLES, START_TIMEOUT_CYCLES, XFER_TIMEOUT_CYCLES));
    localparam logic [3:0] LAST_EDGE = 4'(PS2_TX_FRAME_EDGES - 1);

    ps2_tx_state_t state_q, state_d;
    logic [7:0]    data_q, data_d;
    logic          parity_q, parity_d;
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic          nack_q, nack_d;
    logic          err_q, err_d;
    logic          tmr_load, tmr_zero, fail, finish, expire;
    logic [TW-1:0] tmr_val;
`ifdef PS2_HOST_TX_RETRY_EN
    logic          retry_q, retry_d;
`endif

    ps2_host_tx_timer #(.W(TW)) u_timer (
        .clk_i      (sys_clk),
        .rst_ni     (sys_rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= IDLE;
            data_q   <= '0;
            parity_q <= 1'b0;
            bitcnt_q <= '0;
            nack_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
            retry_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            parity_q <= parity_d;
            bitcnt_q <= bitcnt_d;
            nack_q   <= nack_d;
            err_q    <= err_d;
`ifdef PS2_HOST_TX_RETRY_EN
            retry_q  <= retry_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        parity_d = parity_q;
        bitcnt_d = bitcnt_q;
        nack_d   = nack_q;
        err_d    = err_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        fail     = 1'b0;
        finish   = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
        retry_d  = retry_q;
`endif
        case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    data_d   = tx_data;
                    parity_d = ~^tx_data;
                    bitcnt_d = '0;
                    nack_d   = 1'b0;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(INHIBIT_CYCLES - 1);
                    state_d  = INHIBIT;
`ifdef PS2_HOST_TX_RETRY_EN
                    retry_d  = 1'b0;
`endif
                end
            end
            INHIBIT: begin
                if (tmr_zero) state_d = REQ;
            end
            REQ: begin
                tmr_load = 1'b1;
                tmr_val  = TW'(START_TIMEOUT_CYCLES - 1);
                state_d  = WAIT_START;
            end
            WAIT_START: begin
                if (ps2_clk_negedge) begin
                    bitcnt_d = 4'd1;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(XFER_TIMEOUT_CYCLES - 1);
                    state_d  = SHIFT;
                end else if (tmr_zero) begin
                    fail = 1'b1;
                end
            end
            SHIFT: begin
                if (ps2_clk_negedge) begin
                    if (bitcnt_q == LAST_EDGE) begin
                        nack_d  = ps2_data_in;
                        state_d = WAIT_IDLE;
                    end else begin
                        bitcnt_d = bitcnt_q + 4'd1;
                    end
                end else if (tmr_zero) begin
                    fail = 1'b1;
                end
            end
            WAIT_IDLE: begin
                if (ps2_clk_posedge) begin
                    finish = 1'b1;
                end else if (tmr_zero) begin
                    fail = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (fail || finish) begin
`ifdef PS2_HOST_TX_RETRY_EN
            // One silent resend of the latched byte before reporting a failure.
            if (!retry_q && (fail || nack_q)) begin
                retry_d  = 1'b1;
                bitcnt_d = '0;
                nack_d   = 1'b0;
                tmr_load = 1'b1;
                tmr_val  = TW'(INHIBIT_CYCLES - 1);
                state_d  = INHIBIT;
            end else
`endif
            begin
                err_d   = fail | nack_q;
                state_d = DONE;
            end
        end
    end

    // Lines are dropped in the very cycle a timeout fires, ahead of the state change.
    always_comb begin
        expire      = tmr_zero & ~ps2_clk_negedge;
        tx_ready    = (state_q == IDLE);
        tx_busy     = (state_q != IDLE);
        tx_done     = (state_q == DONE);
        tx_error    = err_q;
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;
        case (state_q)
            INHIBIT:    ps2_clk_oe = 1'b1;
            REQ: begin
                ps2_clk_oe  = 1'b1;
                ps2_data_oe = 1'b1;
            end
            WAIT_START: ps2_data_oe = ~expire;
            SHIFT:      ps2_data_oe = ~frame_bit(data_q, parity_q, bitcnt_q) & ~expire;
            default: begin
                ps2_clk_oe  = 1'b0;
                ps2_data_oe = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - directed self-checking bench for ps2_host_tx with a simple PS/2 device model
module tb_ps2_host_tx;

    localparam int INH = 20;
    localparam int STO = 200;
    localparam int XTO = 400;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       pos = 1'b0;
    logic       neg = 1'b0;
    logic       din = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_data_oe;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   inh_cnt = 0;
    logic done_err = 1'b0;
    logic inh_prev = 1'b0;

    ps2_host_tx #(
        .INHIBIT_CYCLES       (INH),
        .START_TIMEOUT_CYCLES (STO),
        .XFER_TIMEOUT_CYCLES  (XTO)
    ) dut (
        .sys_clk         (sys_clk),
        .sys_rst_n       (sys_rst_n),
        .ps2_clk_posedge (pos),
        .ps2_clk_negedge (neg),
        .ps2_data_in     (din),
        .tx_data         (tx_data),
        .tx_valid        (tx_valid),
        .tx_ready        (tx_ready),
        .tx_busy         (tx_busy),
        .tx_done         (tx_done),
        .tx_error        (tx_error),
        .ps2_clk_oe      (ps2_clk_oe),
        .ps2_data_oe     (ps2_data_oe)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(negedge sys_clk) begin
        if (tx_done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
            done_err = tx_error;
        end
        if (ps2_clk_oe && !ps2_data_oe && !inh_prev) inh_cnt = inh_cnt + 1;
        inh_prev = ps2_clk_oe && !ps2_data_oe;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(negedge sys_clk);
    endtask

    // Accepts a byte and measures the INHIBIT / REQ phases; returns on the first WAIT_START cycle.
    task automatic start_tx(input logic [7:0] d, input logic noise, output int inh, output int req);
        inh = 0;
        req = 0;
        tx_data  = d;
        tx_valid = 1'b1;
        tick;
        tx_valid = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (ps2_clk_oe && !ps2_data_oe) inh++;
            else if (ps2_clk_oe && ps2_data_oe) req++;
            else break;
            neg = noise && (i == 5);
            pos = noise && (i == 5);
            tick;
        end
        neg = 1'b0;
        pos = 1'b0;
    endtask

    // Device clocks n falling/rising pairs; bits[k-1] is the level seen after negedge k.
    task automatic dev_frame(input int n, input logic ack_level, output logic [9:0] bits,
                             output int c_first);
        bits = '1;
        c_first = 0;
        for (int k = 1; k <= n; k++) begin
            if (k == 11) din = ack_level;
            neg = 1'b1;
            tick;
            neg = 1'b0;
            if (k == 1) c_first = cyc;
            tick;
            if (k <= 10) bits[k-1] = ~ps2_data_oe;
            din = 1'b1;
            pos = 1'b1;
            tick;
            pos = 1'b0;
            tick;
            tick;
        end
    endtask

    task automatic test_reset;
        sys_rst_n = 1'b0;
        tick;
        tick;
        total++;
        if ({tx_ready, tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_data_oe} !== 6'b100000) begin
            bad++;
            $display("FAIL reset_outputs: got %b want 100000",
                     {tx_ready, tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_data_oe});
        end
        sys_rst_n = 1'b1;
        tick;
        tick;
    endtask

    task automatic test_ack_ed;
        int inh, req, c1, d0;
        logic [9:0] bits;
        logic [9:0] exp_bits;
        exp_bits = 10'h3ED;
        d0 = done_cnt;
        start_tx(8'hED, 1'b0, inh, req);
        total++;
        if (inh !== INH) begin bad++; $display("FAIL ed_inhibit_cycles: got %0d want %0d", inh, INH); end
        total++;
        if (req !== 1) begin bad++; $display("FAIL ed_req_cycles: got %0d want 1", req); end
        total++;
        if (tx_busy !== 1'b1 || tx_ready !== 1'b0) begin
            bad++;
            $display("FAIL ed_busy_ready: got busy=%b ready=%b want 1 0", tx_busy, tx_ready);
        end
        dev_frame(11, 1'b0, bits, c1);
        for (int k = 0; k < 10; k++) begin
            total++;
            if (bits[k] !== exp_bits[k]) begin
                bad++;
                $display("FAIL ed_bit%0d: got %b want %b", k + 1, bits[k], exp_bits[k]);
            end
        end
        tick;
        total++;
        if (done_cnt - d0 !== 1 || done_err !== 1'b0) begin
            bad++;
            $display("FAIL ed_done: got dones=%0d err=%b want 1 0", done_cnt - d0, done_err);
        end
        total++;
        if (tx_ready !== 1'b1 || tx_error !== 1'b0) begin
            bad++;
            $display("FAIL ed_after: got ready=%b err=%b want 1 0", tx_ready, tx_error);
        end
    endtask

    task automatic test_nack_00;
        int inh, req, c1, d0;
        logic [9:0] bits;
        d0 = done_cnt;
        start_tx(8'h00, 1'b1, inh, req);
        total++;
        if (inh !== INH || req !== 1) begin
            bad++;
            $display("FAIL nack_edges_ignored: got inh=%0d req=%0d want %0d 1", inh, req, INH);
        end
        dev_frame(11, 1'b1, bits, c1);
        total++;
        if (bits !== 10'h300) begin bad++; $display("FAIL nack_bits: got %h want 300", bits); end
        tick;
        total++;
        if (done_cnt - d0 !== 1 || done_err !== 1'b1) begin
            bad++;
            $display("FAIL nack_done: got dones=%0d err=%b want 1 1", done_cnt - d0, done_err);
        end
        repeat (10) tick;
        total++;
        if (tx_error !== 1'b1) begin bad++; $display("FAIL nack_error_hold: got %b want 1", tx_error); end
    endtask

    task automatic test_start_timeout;
        int inh, req, n;
        start_tx(8'hA5, 1'b0, inh, req);
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            if (!(ps2_data_oe && !ps2_clk_oe)) break;
            n++;
            tick;
        end
        total++;
        if (n !== STO - 1) begin bad++; $display("FAIL start_to_drive_cycles: got %0d want %0d", n, STO - 1); end
        total++;
        if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || tx_done !== 1'b0) begin
            bad++;
            $display("FAIL start_to_release: got clk=%b data=%b done=%b want 0 0 0", ps2_clk_oe, ps2_data_oe, tx_done);
        end
        tick;
        total++;
        if (tx_done !== 1'b1 || tx_error !== 1'b1) begin
            bad++;
            $display("FAIL start_to_done: got done=%b err=%b want 1 1", tx_done, tx_error);
        end
        tick;
    endtask

    task automatic test_xfer_timeout;
        int inh, req, c1, n;
        logic [9:0] bits;
        logic p1, p2;
        start_tx(8'h00, 1'b0, inh, req);
        dev_frame(5, 1'b0, bits, c1);
        p1 = ps2_data_oe;
        p2 = p1;
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            if (tx_done) break;
            p2 = p1;
            p1 = ps2_data_oe;
            n++;
            tick;
        end
        total++;
        if (cyc - c1 !== XTO) begin bad++; $display("FAIL xfer_to_latency: got %0d want %0d", cyc - c1, XTO); end
        total++;
        if (p2 !== 1'b1 || p1 !== 1'b0) begin
            bad++;
            $display("FAIL xfer_to_release: got before=%b expiry=%b want 1 0", p2, p1);
        end
        total++;
        if (tx_done !== 1'b1 || tx_error !== 1'b1 || ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
            bad++;
            $display("FAIL xfer_to_done: got done=%b err=%b clk=%b data=%b want 1 1 0 0",
                     tx_done, tx_error, ps2_clk_oe, ps2_data_oe);
        end
        tick;
    endtask

    task automatic test_reset_mid;
        int inh, req, c1, d0;
        logic [9:0] bits;
        start_tx(8'h00, 1'b0, inh, req);
        dev_frame(4, 1'b0, bits, c1);
        total++;
        if (ps2_data_oe !== 1'b1) begin bad++; $display("FAIL rst_mid_pre: got data_oe=%b want 1", ps2_data_oe); end
        d0 = done_cnt;
        #2;
        sys_rst_n = 1'b0;
        #1;
        total++;
        if ({ps2_clk_oe, ps2_data_oe, tx_ready, tx_busy, tx_error} !== 5'b00100) begin
            bad++;
            $display("FAIL rst_mid_async: got %b want 00100", {ps2_clk_oe, ps2_data_oe, tx_ready, tx_busy, tx_error});
        end
        tick;
        tick;
        sys_rst_n = 1'b1;
        repeat (30) tick;
        total++;
        if (done_cnt !== d0 || tx_busy !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_no_done: got dones=%0d busy=%b want 0 0", done_cnt - d0, tx_busy);
        end
    endtask

`ifdef PS2_HOST_TX_RETRY_EN
    task automatic test_retry;
        int inh, req, c1, d0, i0;
        logic [9:0] b1, b2;
        d0 = done_cnt;
        i0 = inh_cnt;
        start_tx(8'hED, 1'b0, inh, req);
        dev_frame(11, 1'b1, b1, c1);
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        repeat (3) tick;
        tx_valid = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (!ps2_clk_oe && ps2_data_oe) break;
            tick;
        end
        total++;
        if (done_cnt !== d0) begin bad++; $display("FAIL retry_no_first_done: got %0d want 0", done_cnt - d0); end
        dev_frame(11, 1'b0, b2, c1);
        tick;
        total++;
        if (b1 !== 10'h3ED || b2 !== 10'h3ED) begin
            bad++;
            $display("FAIL retry_bits: got %h %h want 3ed 3ed", b1, b2);
        end
        total++;
        if (inh_cnt - i0 !== 2) begin bad++; $display("FAIL retry_inhibits: got %0d want 2", inh_cnt - i0); end
        total++;
        if (done_cnt - d0 !== 1 || done_err !== 1'b0) begin
            bad++;
            $display("FAIL retry_done: got dones=%0d err=%b want 1 0", done_cnt - d0, done_err);
        end
        repeat (40) tick;
        total++;
        if (tx_busy !== 1'b0 || inh_cnt - i0 !== 2) begin
            bad++;
            $display("FAIL retry_busy_valid_ignored: got busy=%b inh=%0d want 0 2", tx_busy, inh_cnt - i0);
        end
    endtask
`endif

    initial begin
        test_reset;
`ifdef PS2_HOST_TX_RETRY_EN
        test_retry;
`else
        test_ack_ed;
        test_nack_00;
        test_start_timeout;
        test_xfer_timeout;
        test_reset_mid;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
